// File: rtl/apb4_completer_mem.sv
// rtl/apb4_completer_mem.sv - APB4 completer backed by a word-addressed SRAM model
// Byte strobes, per-direction wait states, and PSLVERR on misaligned or out-of-range accesses.
module apb4_completer_mem #(
  parameter int AddressWidth    = 20,
  parameter int DataWidth       = 32,
  parameter int MemDepthWords   = 1024,
  parameter int ReadWaitStates  = 0,
  parameter int WriteWaitStates = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AddressWidth-1:0]  paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [DataWidth-1:0]     pwdata,
  input  logic [DataWidth/8-1:0]   pstrb,
  output logic [DataWidth-1:0]     prdata,
  output logic                     pready,
  output logic                     pslverr
);

  localparam int NumBytes = DataWidth / 8;
  localparam int AddrLsb  = $clog2(NumBytes);
  localparam int IdxW     = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;
  localparam logic [AddressWidth-1:0] LsbMask = AddressWidth'((64'd1 << AddrLsb) - 64'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic                   write_q;
  logic                   err_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [NumBytes-1:0]    strb_q;
  logic                   pready_q;
  logic                   pslverr_q;
  logic [DataWidth-1:0]   prdata_q;

  logic [DataWidth-1:0]   mem [MemDepthWords];

  logic [AddressWidth-1:0] word_full;
  logic [IdxW-1:0]         setup_idx;
  logic                    setup_err;
  logic [3:0]              setup_wait;
  logic                    fin_write;
  logic                    fin_err;
  logic [IdxW-1:0]         fin_idx;
  logic [DataWidth-1:0]    fin_rdata;
  logic                    commit;

  // In IDLE the transfer may finish straight from setup, so use live bus values there.
  always_comb begin
    word_full  = paddr >> AddrLsb;
    setup_idx  = word_full[IdxW-1:0];
    setup_err  = (|(paddr & LsbMask)) || (64'(word_full) >= 64'(MemDepthWords));
    setup_wait = pwrite ? 4'(WriteWaitStates) : 4'(ReadWaitStates);
    fin_write  = write_q;
    fin_err    = err_q;
    fin_idx    = idx_q;
    if (state_q == ST_IDLE) begin
      fin_write = pwrite;
      fin_err   = setup_err;
      fin_idx   = setup_idx;
    end
    fin_rdata = (!fin_write && !fin_err) ? mem[fin_idx] : '0;
    commit    = (state_q == ST_DONE) && write_q && !err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            idx_q   <= setup_idx;
            write_q <= pwrite;
            err_q   <= setup_err;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            if (setup_wait == 4'd0) begin
              state_q   <= ST_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= setup_err;
              prdata_q  <= fin_rdata;
            end else begin
              cnt_q   <= setup_wait;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (penable) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q   <= ST_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= fin_rdata;
            end
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage is not reset; a reset forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_completer_mem.sv
// tb/tb_apb4_completer_mem.sv - directed self-checking bench for apb4_completer_mem
// Three instances: defaults, (read 3 / write 1) wait states, (read 3 / write 4) wait states.
module tb_apb4_completer_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] paddr;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prd0, prd1, prd2;
  logic        rdy0, rdy1, rdy2;
  logic        serr0, serr1, serr2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int setup_cyc;
  int done_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_completer_mem u0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd0), .pready(rdy0), .pslverr(serr0)
  );

  apb4_completer_mem #(.ReadWaitStates(3), .WriteWaitStates(1)) u1 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd1), .pready(rdy1), .pslverr(serr1)
  );

  apb4_completer_mem #(.ReadWaitStates(3), .WriteWaitStates(4)) u2 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prd2), .pready(rdy2), .pslverr(serr2)
  );

  function automatic logic dev_rdy(input int dev);
    return (dev == 0) ? rdy0 : (dev == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic dev_serr(input int dev);
    return (dev == 0) ? serr0 : (dev == 1) ? serr1 : serr2;
  endfunction

  function automatic logic [31:0] dev_prd(input int dev);
    return (dev == 0) ? prd0 : (dev == 1) ? prd1 : prd2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup_access(input int dev, input logic wr, input logic [19:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    psel = 3'b000;
    psel[dev] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    pstrb = s;
    setup_cyc = cyc;
    @(posedge clk); #1;
    penable = 1'b1;
  endtask

  // Ends at the falling edge of the completing cycle, so the next call is back-to-back.
  task automatic apb(input int dev, input logic wr, input logic [19:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er, output int acc);
    logic got;
    got = 1'b0;
    rd = '0;
    er = 1'b0;
    acc = 0;
    setup_access(dev, wr, a, d, s);
    for (int k = 0; k < 40 && !got; k++) begin
      acc++;
      @(negedge clk);
      if (dev_rdy(dev)) begin
        got = 1'b1;
        rd = dev_prd(dev);
        er = dev_serr(dev);
        done_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("handshake", 32'(got), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int acc;
    int s0;
    logic any;

    rst_n = 1'b0;
    psel = 3'b000;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready0", 32'(rdy0), 32'd0);
    chk("reset_prdata0", prd0, 32'd0);
    chk("reset_pslverr0", 32'(serr0), 32'd0);
    chk("reset_pready2", 32'(rdy2), 32'd0);
    rst_n = 1'b1;

    apb(0, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, rd, er, acc);
    chk("dflt_wr_acc", 32'(acc), 32'd1);
    chk("dflt_wr_err", 32'(er), 32'd0);
    apb(0, 1'b0, 20'h00010, 32'h0, 4'h0, rd, er, acc);
    chk("dflt_rd_acc", 32'(acc), 32'd1);
    chk("dflt_rd_data", rd, 32'hDEADBEEF);
    chk("dflt_rd_err", 32'(er), 32'd0);
    idle();

    apb(0, 1'b1, 20'h00020, 32'hDEADBEEF, 4'hF, rd, er, acc);
    apb(0, 1'b1, 20'h00020, 32'h11223344, 4'b0101, rd, er, acc);
    apb(0, 1'b0, 20'h00020, 32'h0, 4'h0, rd, er, acc);
    chk("strobe_data", rd, 32'hDE22BE44);
    apb(0, 1'b1, 20'h00020, 32'hFFFFFFFF, 4'b0000, rd, er, acc);
    chk("strobe0_err", 32'(er), 32'd0);
    apb(0, 1'b0, 20'h00020, 32'h0, 4'h0, rd, er, acc);
    chk("strobe0_data", rd, 32'hDE22BE44);
    idle();

    apb(1, 1'b1, 20'h00004, 32'h89ABCDEF, 4'hF, rd, er, acc);
    chk("ws_wr_acc", 32'(acc), 32'd2);
    apb(1, 1'b0, 20'h00004, 32'h0, 4'h0, rd, er, acc);
    chk("ws_rd_acc", 32'(acc), 32'd4);
    chk("ws_rd_data", rd, 32'h89ABCDEF);
    idle();

    apb(0, 1'b1, 20'h00000, 32'h01020304, 4'hF, rd, er, acc);
    apb(0, 1'b1, 20'h00FFC, 32'h13572468, 4'hF, rd, er, acc);
    apb(0, 1'b0, 20'h00002, 32'h0, 4'h0, rd, er, acc);
    chk("misal_acc", 32'(acc), 32'd1);
    chk("misal_err", 32'(er), 32'd1);
    chk("misal_data", rd, 32'd0);
    apb(0, 1'b1, 20'h01000, 32'hCAFEF00D, 4'hF, rd, er, acc);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", rd, 32'd0);
    apb(0, 1'b0, 20'h00FFC, 32'h0, 4'h0, rd, er, acc);
    chk("last_word_data", rd, 32'h13572468);
    chk("last_word_err", 32'(er), 32'd0);
    apb(0, 1'b0, 20'h00000, 32'h0, 4'h0, rd, er, acc);
    chk("word0_untouched", rd, 32'h01020304);
    idle();

    @(posedge clk); #1;
    psel = 3'b001;
    penable = 1'b1;
    pwrite = 1'b0;
    paddr = 20'h00010;
    any = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any = any | rdy0;
    end
    idle();
    chk("proto_ignored", 32'(any), 32'd0);

    apb(2, 1'b1, 20'h00008, 32'hA5A5A5A5, 4'hF, rd, er, acc);
    chk("ws4_wr_acc", 32'(acc), 32'd5);
    idle();
    setup_access(2, 1'b1, 20'h00008, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("abort_wait1", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_wait2", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    psel = 3'b000;
    penable = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any = any | rdy2;
    end
    chk("abort_no_ready", 32'(any), 32'd0);
    apb(2, 1'b0, 20'h00008, 32'h0, 4'h0, rd, er, acc);
    chk("abort_old_data", rd, 32'hA5A5A5A5);
    chk("abort_rd_acc", 32'(acc), 32'd4);
    idle();

    for (int j = 0; j < 8; j++) begin
      apb(0, 1'b1, 20'(32'h200 + 4 * j), 32'h5A000000 + 32'h01010101 * (j + 1), 4'hF, rd, er, acc);
      if (j == 0) s0 = setup_cyc;
      chk("b2b_wr_acc", 32'(acc), 32'd1);
    end
    for (int j = 0; j < 8; j++) begin
      apb(0, 1'b0, 20'(32'h200 + 4 * j), 32'h0, 4'h0, rd, er, acc);
      chk("b2b_rd_data", rd, 32'h5A000000 + 32'h01010101 * (j + 1));
    end
    chk("b2b_cycles", 32'(done_cyc - s0), 32'd31);
    idle();

    setup_access(0, 1'b0, 20'h00010, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_done_ready", 32'(rdy0), 32'd1);
    chk("rst_done_data", prd0, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ready", 32'(rdy0), 32'd0);
    chk("rst_async_data", prd0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 3'b000;
    penable = 1'b0;

    setup_access(0, 1'b1, 20'h00010, 32'h55555555, 4'hF);
    @(negedge clk);
    chk("rst_wr_ready", 32'(rdy0), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 3'b000;
    penable = 1'b0;
    apb(0, 1'b0, 20'h00010, 32'h0, 4'h0, rd, er, acc);
    chk("rst_wr_dropped", rd, 32'hDEADBEEF);
    idle();

    setup_access(2, 1'b0, 20'h00008, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_wait_ready_pre", 32'(rdy2), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(rdy2), 32'd0);
    chk("rst_wait_data", prd2, 32'd0);
    chk("rst_wait_err", 32'(serr2), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 3'b000;
    penable = 1'b0;
    apb(2, 1'b0, 20'h00008, 32'h0, 4'h0, rd, er, acc);
    chk("post_rst_data", rd, 32'hA5A5A5A5);
    chk("post_rst_acc", 32'(acc), 32'd4);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
